shift_arbiter: RTL and testbench

- Shares one combinational left/right bits shifter between two requesters. Requester handshakes are valid/ready; the single response channel is valid/ready with a requester ID.
- Round-robin arbitration, one registered result stage, and a completed-operation counter for the status path.
- Sits between request sources (e.g. a barrel-shift command decoder and a test DMA) and the shifter datapath. The shifter is instantiated internally.

---
 rtl/shift_arbiter.sv | 82 ++++++++
 tb/tb_shift_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one logical shifter between two requesters
module shift_arbiter #(
    parameter int width     = 8,
    parameter int cnt_width = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [width-1:0]           req0_bits,
    input  logic [$clog2(width)-1:0]   req0_shift,
    input  logic                       req0_dir,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [width-1:0]           req1_bits,
    input  logic [$clog2(width)-1:0]   req1_shift,
    input  logic                       req1_dir,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [width-1:0]           resp_bits,
    output logic                       resp_id,
    output logic [cnt_width-1:0]       op_count
);

    localparam int sw = $clog2(width);

    logic             ptr;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic [width-1:0] sel_bits;
    logic [sw-1:0]    sel_shift;
    logic             sel_dir;
    logic [width-1:0] shifted;

    // Ready is held low during reset so no command is consumed while state is cleared.
    always_comb begin
        can_accept = !resp_valid || resp_ready;
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (rst && can_accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = !ptr;
                grant1 = ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_bits  = grant1 ? req1_bits  : req0_bits;
    assign sel_shift = grant1 ? req1_shift : req0_shift;
    assign sel_dir   = grant1 ? req1_dir   : req0_dir;
    assign shifted   = sel_dir ? (sel_bits >> sel_shift) : (sel_bits << sel_shift);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_bits  <= '0;
            resp_id    <= 1'b0;
            ptr        <= 1'b0;
            op_count   <= '0;
        end else begin
            if (grant0 || grant1) begin
                resp_valid <= 1'b1;
                resp_bits  <= shifted;
                resp_id    <= grant1;
                ptr        <= !grant1;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (resp_valid && resp_ready) begin
                op_count <= op_count + {{(cnt_width-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter
module tb_shift_arbiter;

    localparam int W  = 8;
    localparam int SW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_bits = '0, req1_bits = '0;
    logic [SW-1:0] req0_shift = '0, req1_shift = '0;
    logic          req0_dir = 1'b0, req1_dir = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  resp_bits;
    logic          resp_id;
    logic [CW-1:0] op_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [W:0]    q[$];
    logic [CW-1:0] m_cnt = '0;
    logic          m_ptr = 1'b0;

    shift_arbiter #(.width(W), .cnt_width(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bits(req0_bits),
        .req0_shift(req0_shift), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bits(req1_bits),
        .req1_shift(req1_shift), .req1_dir(req1_dir),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bits(resp_bits),
        .resp_id(resp_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] b, input logic [SW-1:0] s,
                                               input logic d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (!d && i >= int'(s)) r[i] = b[i-int'(s)];
            if (d && i + int'(s) < W) r[i] = b[i+int'(s)];
        end
        return r;
    endfunction

    // Reference arbiter and result register, evaluated mid-cycle.
    always @(negedge clk) begin
        logic m_full, e_can, e_g0, e_g1;
        if (!rst) begin
            vectors++;
            if (resp_valid !== 1'b0 || resp_bits !== '0 || resp_id !== 1'b0 || op_count !== '0
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: valid=%b bits=%h id=%b cnt=%0d rdy=%b%b, required all 0",
                         resp_valid, resp_bits, resp_id, op_count, req0_ready, req1_ready);
            end
            q.delete();
            m_cnt = '0;
            m_ptr = 1'b0;
        end else begin
            m_full = (q.size() != 0);
            e_can  = !m_full || resp_ready;
            e_g0   = e_can && req0_valid && (!req1_valid || !m_ptr);
            e_g1   = e_can && req1_valid && (!req0_valid || m_ptr);
            vectors++;
            if ({req0_ready, req1_ready} !== {e_g0, e_g1}) begin
                miscompares++;
                $display("FAIL grant: ready=%b%b required %b%b", req0_ready, req1_ready, e_g0, e_g1);
            end
            vectors++;
            if (resp_valid !== m_full) begin
                miscompares++;
                $display("FAIL resp_valid: got %b required %b", resp_valid, m_full);
            end
            if (m_full) begin
                vectors++;
                if ({resp_id, resp_bits} !== q[0]) begin
                    miscompares++;
                    $display("FAIL resp_data: id/bits got %b/%h required %b/%h",
                             resp_id, resp_bits, q[0][W], q[0][W-1:0]);
                end
            end
            vectors++;
            if (op_count !== m_cnt) begin
                miscompares++;
                $display("FAIL op_count: got %0d required %0d", op_count, m_cnt);
            end
            if (m_full && resp_ready) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (e_g0) begin
                q.push_back({1'b0, ref_shift(req0_bits, req0_shift, req0_dir)});
                m_ptr = 1'b1;
            end else if (e_g1) begin
                q.push_back({1'b1, ref_shift(req1_bits, req1_shift, req1_dir)});
                m_ptr = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if (req0_ready !== 1'b0 || resp_valid !== 1'b0 || op_count !== '0) begin
            miscompares++;
            $display("FAIL test_reset: rdy=%b valid=%b cnt=%0d required 0/0/0", req0_ready, resp_valid, op_count);
        end
        req0_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        req0_bits = 8'h81; req0_shift = 3'd1; req0_dir = 1'b0; req0_valid = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: got %b required 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_bits !== 8'h02 || resp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL single_resp: got %b/%h/%b required 1/02/0", resp_valid, resp_bits, resp_id);
        end
        @(posedge clk); #1;
        vectors++;
        if (op_count !== 4'd1 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_count: got cnt=%0d valid=%b required 1/0", op_count, resp_valid);
        end
    endtask

    task automatic test_right_boundary();
        logic [W-1:0] bits_tab[2]  = '{8'hF0, 8'hA5};
        logic [SW-1:0] sh_tab[2]   = '{3'd7, 3'd0};
        logic [W-1:0] exp_tab[2]   = '{8'h01, 8'hA5};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            req1_bits = bits_tab[i]; req1_shift = sh_tab[i]; req1_dir = 1'b1; req1_valid = 1'b1;
            @(negedge clk); #1;
            @(posedge clk); #1;
            req1_valid = 1'b0;
            @(negedge clk); #1;
            vectors++;
            if (resp_bits !== exp_tab[i] || resp_id !== 1'b1) begin
                miscompares++;
                $display("FAIL right_%0d: got %h/%b required %h/1", i, resp_bits, resp_id, exp_tab[i]);
            end
        end
        @(posedge clk);
    endtask

    task automatic test_contention();
        do_reset();
        @(posedge clk); #1;
        req0_bits = 8'h11; req0_shift = 3'd1; req0_dir = 1'b0;
        req1_bits = 8'h88; req1_shift = 3'd3; req1_dir = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL contention_grant_%0d: got %b%b", i, req0_ready, req1_ready);
            end
            if (i > 0) begin
                vectors++;
                if (resp_id !== 1'((i - 1) % 2)) begin
                    miscompares++;
                    $display("FAIL contention_id_%0d: got %b required %0d", i, resp_id, (i - 1) % 2);
                end
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (resp_id !== 1'b1 || resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL contention_last: got id=%b valid=%b required 1/1", resp_id, resp_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (op_count !== 4'd4 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL contention_count: got %0d/%b required 4/0", op_count, resp_valid);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        req0_bits = 8'h3C; req0_shift = 3'd2; req0_dir = 1'b0;
        req1_bits = 8'h3C; req1_shift = 3'd2; req1_dir = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_first: got %b%b required 10", req0_ready, req1_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp_valid !== 1'b1
                || resp_bits !== 8'hF0 || op_count !== 4'd4) begin
                miscompares++;
                $display("FAIL bp_stall_%0d: rdy=%b%b valid=%b bits=%h cnt=%0d required 00/1/F0/4",
                         i, req0_ready, req1_ready, resp_valid, resp_bits, op_count);
            end
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got %b%b required 01", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (resp_id !== 1'b1 || resp_bits !== 8'h0F || op_count !== 4'd5) begin
            miscompares++;
            $display("FAIL bp_next: got %b/%h/%0d required 1/0F/5", resp_id, resp_bits, op_count);
        end
        @(posedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (op_count !== 4'd6 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: got %0d/%b required 6/0", op_count, resp_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(posedge clk); #1;
        resp_ready = 1'b1;
        req0_bits = 8'h5A; req0_shift = 3'd0; req0_dir = 1'b0; req0_valid = 1'b1;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk); #1;
            if (c >= 16) begin
                vectors++;
                if (op_count !== 4'((c - 1) % 16)) begin
                    miscompares++;
                    $display("FAIL wrap_%0d: got %0d required %0d", c, op_count, (c - 1) % 16);
                end
            end
            @(posedge clk); #1;
            req0_valid = (c < 16);
            req0_bits  = W'($urandom);
            req0_shift = SW'($urandom);
            req0_dir   = 1'($urandom);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        req1_bits = 8'hFF; req1_shift = 3'd0; req1_dir = 1'b0; req1_valid = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || op_count !== '0 || resp_bits !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %b/%0d/%h required 0/0/00", resp_valid, op_count, resp_bits);
        end
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        req0_bits = 8'h01; req0_shift = 3'd7; req0_dir = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_first_grant: got %b%b required 10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (resp_bits !== 8'h80 || resp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL async_first_resp: got %h/%b required 80/0", resp_bits, resp_id);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_right_boundary();
        test_contention();
        test_backpressure();
        test_wrap();
        test_async_reset();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
